// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
//   - MDU_WIDTH     : default operand width
//   - OP_*          : op encodings driven on the op port
//   - mdu_state_e   : FSM states (IDLE, CALC, FIX)
//   - op_is_signed  : helper decoding signedness from op
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_e;

   // Signed ops have op[0] clear (MULT, DIV)
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Ports:
//   rem_i     - current partial remainder (always < divisor)
//   dbit_i    - next dividend bit shifted in
//   divisor_i - divisor magnitude
//   rem_o     - next partial remainder
//   q_o       - quotient bit produced by this step
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dbit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Trial subtract; a borrow into the top bit means the divisor did not fit
   always_comb begin
      shifted = {rem_i, dbit_i};
      trial   = shifted - {1'b0, divisor_i};
      q_o     = ~trial[WIDTH];
      rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional feature macro: MDU_FAST_MULT_EN (single-cycle multiplier,
// multiplies skip CALC; divides stay iterative).
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, op, a, b - launch request (sampled only in IDLE), opcode, operands
//   hi_we, lo_we    - MTHI/MTLO strobes, honoured only in IDLE
//   wdata           - MTHI/MTLO data
//   busy            - operation in flight (for hazard stalls)
//   done            - one-cycle pulse when HI/LO take a result
//   hi, lo          - architectural HI/LO registers
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] mag_a_q, mag_a_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [WIDTH-1:0] a_orig_q, a_orig_d;
   logic             neg_q, neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             dz_q, dz_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             a_neg, b_neg;
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    mul_next;
   logic [W2-1:0]    div_next;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   // Divide step works on acc = {partial remainder, remaining dividend bits}
   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (acc_q[W2-1:WIDTH]),
      .dbit_i    (acc_q[WIDTH-1]),
      .divisor_i (mag_b_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // Next-state, datapath and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      a_orig_d  = a_orig_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      acc_d     = acc_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      a_neg = op_is_signed(op) & a[WIDTH-1];
      b_neg = op_is_signed(op) & b[WIDTH-1];

      // Shift-add multiply: acc = {partial product, unconsumed multiplier}
      mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + ({1'b0, mag_a_q} & {(WIDTH+1){acc_q[0]}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      div_next = {step_rem, acc_q[WIDTH-2:0], step_q};

      prod_fix = neg_q     ? (~acc_q + W2'(1))                 : acc_q;
      quo_fix  = neg_q     ? (~acc_q[WIDTH-1:0] + WIDTH'(1))   : acc_q[WIDTH-1:0];
      rem_fix  = rem_neg_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1))  : acc_q[W2-1:WIDTH];

      case (state_q)
         ST_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               is_div_d  = op[1];
               mag_a_d   = a_neg ? (~a + WIDTH'(1)) : a;
               mag_b_d   = b_neg ? (~b + WIDTH'(1)) : b;
               a_orig_d  = a;
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               dz_d      = op[1] & (b == '0);
               acc_d     = {WIDTH'(0), (op[1] ? mag_a_d : mag_b_d)};
               cnt_d     = CW'(WIDTH);
               state_d   = ST_CALC;
`ifdef MDU_FAST_MULT_EN
               // Fast multiply: one FIX cycle to form the product, one to write it
               if (!op[1]) begin
                  cnt_d   = CW'(1);
                  state_d = ST_FIX;
               end
`endif
            end
         end

         ST_CALC: begin
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_FIX: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
`ifdef MDU_FAST_MULT_EN
               acc_d = W2'(mag_a_q) * W2'(mag_b_q);
`endif
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[W2-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dz_q) begin
                  hi_d = a_orig_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // busy rises one edge after launch and drops with the writeback edge
      busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         a_orig_q  <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         a_orig_q  <= a_orig_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int unsigned W = 32;
   localparam int DIV_LAT = W + 2;
`ifdef MDU_FAST_MULT_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = W + 2;
`endif

   logic         clk, reset, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int tests = 0;
   int fails = 0;
   int done_k, busy_cnt, done_cnt;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one op; count busy cycles and the edge index of done (0 = timeout).
   // poke_at>0 drives an illegal start+MTHI while the op is in flight.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int poke_at);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_k = 0;
      busy_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         hi_we = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_k = k;
            break;
         end
         if (k == poke_at) begin
            start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
            hi_we = 1'b1; wdata = 32'hDEADBEEF;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int lat, input int poke_at);
      run_op(o, x, y, poke_at);
      check({tag, " latency"}, W'(done_k), W'(lat));
      check({tag, " busy_cycles"}, W'(busy_cnt), W'(lat - 1));
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      @(negedge clk);
      check({tag, " done_pulse"}, W'(done), W'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = OP_MULT; a = '0; b = '0; wdata = '0;
      #1;
      check("reset busy", W'(busy), W'(0));
      check("reset done", W'(done), W'(0));
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, 0);
      do_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, 0);
      do_op("mult_6xm2", OP_MULT,  32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, MUL_LAT, 0);
      do_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, 0);
      do_op("divu",      OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 0);
      do_op("divu_zero", OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_LAT, 0);
      do_op("div_zero",  OP_DIV,   32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, DIV_LAT, 0);
      do_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_LAT, 0);

      // Start and MTHI during a divide must both be ignored
      do_op("div_poke",  OP_DIV,   32'd1000, 32'd9, 32'd1, 32'd111, DIV_LAT, 5);

      // MTHI in IDLE lands; LO untouched
      hi_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi hi", hi, 32'h12345678);
      check("mthi lo", lo, 32'd111);

      // Asynchronous reset mid-CALC abandons the op immediately
      op = OP_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) @(negedge clk);
      check("pre_reset busy", W'(busy), W'(1));
      #2 reset = 1'b1;
      #1;
      check("async busy", W'(busy), W'(0));
      check("async done", W'(done), W'(0));
      check("async hi", hi, 32'h0);
      check("async lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("no_done_after_reset", W'(done_cnt), W'(0));

      do_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT, 0);

      // MTLO in IDLE
      lo_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo lo", lo, 32'hCAFEF00D);
      check("mtlo hi", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative MIPS multiply/divide unit in the EX stage. Executes MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers. Feeds HI/LO values into the downstream pipeline register for MFHI/MFLO. Exposes busy so hazard logic can stall the pipeline registers in front of it.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk      input   1        rising-edge clock
reset    input   1        asynchronous, active-high reset
start    input   1        launch operation; sampled only in IDLE
op       input   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a        input   WIDTH    rs operand (multiplicand / dividend)
b        input   WIDTH    rt operand (multiplier / divisor)
hi_we    input   1        MTHI write strobe
lo_we    input   1        MTLO write strobe
wdata    input   WIDTH    MTHI/MTLO data
busy     output  1        operation in flight
done     output  1        one-cycle pulse when HI/LO are updated
hi       output  WIDTH    HI register
lo       output  WIDTH    LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset, asserted at any time including mid-operation: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. The in-flight operation is abandoned and no result is written.
- FSM states:
  - IDLE -> CALC on start.
  - CALC holds for WIDTH cycles, one shift-add or restore-subtract step per cycle, with a down-counter.
  - CALC -> FIX when the counter reaches 0.
  - FIX -> IDLE unconditionally.
- Start capture (edge N, state IDLE):
  - Latch op.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch result-sign flags.
  - Latch a div-by-zero flag (b==0 and op is DIV/DIVU).
- Timing:
  - busy is registered and high for cycles N+1 through N+WIDTH+1.
  - At edge N+WIDTH+2: hi/lo update, done=1 for exactly one cycle, busy=0.
  - Latency is fixed; it is independent of operand values and div-by-zero.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. Signed: two's-complement negate the 2W-bit magnitude in FIX when operand signs differ.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient is negated when operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Division special cases:
  - Divide by zero (signed or unsigned): lo = all ones, hi = original a.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, produced by the normal magnitude path with no special case.
- start while busy=1 is ignored; there is no queue. start in the done cycle is accepted (state is IDLE).
- hi_we/lo_we:
  - Take effect at the edge only while state is IDLE.
  - Ignored while busy.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, the write lands immediately and is later overwritten by the result.
- hi/lo change only on reset, an IDLE-state write, or result writeback.

Optional Feature:
MDU_FAST_MULT_EN
- Defined: MULT/MULTU skip CALC (IDLE -> FIX). The product is computed with a single-cycle multiplier; busy is high for cycle N+1 only; result and done appear at edge N+2.
- Undefined: all ops are iterative as above. Divide is unaffected either way.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - the default WIDTH constant.
- One sub-module, mdu_div_step: combinational single restoring-division step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder and quotient bit.
- Multiply step stays inline.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge N -> busy cycles N+1..N+33; edge N+34: hi=0xFFFFFFFE, lo=0x00000001, done pulse of one cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, same 34-edge latency. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a DIV, then pulse start with op=MULT and hi_we with wdata=0xDEADBEEF mid-operation -> both ignored; DIV result is written; afterwards hi_we in IDLE with wdata=0x12345678 -> hi=0x12345678, lo unchanged.
- Assert reset asynchronously between clock edges during cycle 10 of CALC -> busy, done, hi, lo go to 0 immediately; no done pulse later; a fresh MULTU 3*4 then gives lo=12, hi=0.
- Build with MDU_FAST_MULT_EN: MULT 6*(-2) -> done at edge N+2, hi=0xFFFFFFFF, lo=0xFFFFFFF4; DIVU 100/7 still takes 34 edges.
